// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : KGP-RISC front end. Owns the PC, fetches instruction words over a
//            req/valid handshake, and presents decoded fields to control over
//            a valid/ready handshake. Handles redirects and stale fetches.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              PC_STEP     = 4,
    parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,

    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [15:0]       imm16,
    output logic [25:0]       imm26,
    output logic [ADDR_W-1:0] instr_pc,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_discard;
    logic [31:0]        r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_instr_valid;
    logic               r_halted;

    logic               w_accept;
    logic               w_is_halt;

    assign w_accept  = r_instr_valid && instr_ready;
    assign w_is_halt = (r_instr[31:26] == HALT_OPCODE);

    // The request is a decode of the state flop; it is masked while reset is
    // held so memory never sees a request from a core that is being reset.
    assign imem_req    = (r_state == S_FETCH) && !rst;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;
    assign instr_pc    = r_instr_pc;

    assign opcode = r_instr[31:26];
    assign rs     = r_instr[25:21];
    assign rt     = r_instr[20:16];
    assign imm16  = r_instr[15:0];
    assign imm26  = r_instr[25:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_discard     <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_WAIT;
                    // The request just issued targets the old PC; mark it stale.
                    if (redirect_valid) begin
                        r_pc      <= redirect_pc;
                        r_discard <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem_valid) begin
                        if (r_discard || redirect_valid) begin
                            r_discard <= 1'b0;
                            r_state   <= S_FETCH;
                        end else begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_state       <= S_ISSUE;
                        end
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    if (w_accept) begin
                        r_instr_valid <= 1'b0;
                        r_pc <= redirect_valid ? redirect_pc : (r_instr_pc + PC_INC);
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_state  <= S_FETCH;
                        end
                    end else if (redirect_valid) begin
                        // Presented instruction is on the wrong path; drop it.
                        r_pc          <= redirect_pc;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end

                S_HALT: begin
                    r_halted <= 1'b1;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed, table-driven bench for instr_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .imm16          (imm16),
        .imm26          (imm26),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_word;
        logic        cf;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic iv, logic [31:0] rd, logic rdy,
                                logic rv, logic [31:0] rpc, logic chk,
                                logic ereq, logic [31:0] eaddr, logic evalid,
                                logic [31:0] epc, logic [31:0] eword, logic cf,
                                logic ehalt);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.rdata = rd;  v.rdy = rdy;  v.rv = rv;  v.rpc = rpc;
        v.chk = chk;  v.e_req = ereq;  v.e_addr = eaddr;  v.e_valid = evalid;
        v.e_pc = epc;  v.e_word = eword;  v.cf = cf;  v.e_halt = ehalt;
        return v;
    endfunction

    task automatic cmp(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    task automatic check_fields(input int idx, input logic [31:0] w, input logic [31:0] pc);
        logic [31:0] wv;
        wv = w;
        cmp(idx, "instr_pc", instr_pc, pc);
        cmp(idx, "opcode", {26'd0, opcode}, {26'd0, wv[31:26]});
        cmp(idx, "rs", {27'd0, rs}, {27'd0, wv[25:21]});
        cmp(idx, "rt", {27'd0, rt}, {27'd0, wv[20:16]});
        cmp(idx, "imm16", {16'd0, imm16}, {16'd0, wv[15:0]});
        cmp(idx, "imm26", {6'd0, imm26}, {6'd0, wv[25:0]});
    endtask

    initial begin
        int got;
        int reqs;

        rst = 1'b1;  imem_valid = 1'b0;  imem_rdata = '0;  instr_ready = 1'b0;
        redirect_valid = 1'b0;  redirect_pc = '0;

        //            rst iv rdata          rdy rv rpc           chk req addr          vld pc            word           cf hlt
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 0
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        1, 0)); // 1 reset
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 2 fetch 0
        vecs.push_back(mk(0, 1, 32'h0000_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 3
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        32'h0,        1, 0)); // 4 issue @0
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h4,        0, 32'h0,        32'h0,        0, 0)); // 5 fetch 4
        vecs.push_back(mk(0, 1, 32'h8000_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 6
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 7 stall
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 8
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF,0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 9 stray valid
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 10
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 11
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h4,        32'h8000_0000,1, 0)); // 12 accept
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h8,        0, 32'h0,        32'h0,        0, 0)); // 13 fetch 8
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h40,       1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 14 redirect in WAIT
        vecs.push_back(mk(0, 1, 32'h0400_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 15 stale data
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h40,       0, 32'h0,        32'h0,        0, 0)); // 16 fetch 0x40
        vecs.push_back(mk(0, 1, 32'h0800_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 17
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h100,      1, 0, 32'h0,        1, 32'h40,       32'h0800_0000,1, 0)); // 18 accept+redirect
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        32'h0,        0, 0)); // 19 fetch 0x100
        vecs.push_back(mk(0, 1, 32'hFC00_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 20 halt word
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      32'hFC00_0000,1, 0)); // 21
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h100,      32'hFC00_0000,1, 0)); // 22 accept halt
        vecs.push_back(mk(0, 1, 32'h0,        0, 1, 32'h200,      1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1)); // 23 halted
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1)); // 24
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1)); // 25 reset
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0,        1, 0)); // 26 restart
        vecs.push_back(mk(0, 1, 32'h1234_5678,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 27
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h0,        32'h1234_5678,1, 0)); // 28 all fields
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC,1, 1, 32'h4,        0, 32'h0,        32'h0,        0, 0)); // 29 redirect in FETCH
        vecs.push_back(mk(0, 1, 32'h0400_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 30 stale data
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC,0, 32'h0,        32'h0,        0, 0)); // 31
        vecs.push_back(mk(0, 1, 32'h0C00_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 32
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC,32'h0C00_0000,1, 0)); // 33 accept at top
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 34 wrapped to 0
        vecs.push_back(mk(0, 1, 32'h1000_0000,0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 35
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h80,       1, 0, 32'h0,        1, 32'h0,        32'h1000_0000,1, 0)); // 36 redirect, no accept
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h80,       0, 32'h0,        32'h0,        0, 0)); // 37
        vecs.push_back(mk(0, 1, 32'h1400_0000,0, 1, 32'hC0,       1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0)); // 38 redirect+valid
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hC0,       0, 32'h0,        32'h0,        0, 0)); // 39

        foreach (vecs[i]) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            imem_valid     = vecs[i].iv;
            imem_rdata     = vecs[i].rdata;
            instr_ready    = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            if (vecs[i].chk) begin
                n_vec++;
                cmp(i, "imem_req", {31'd0, imem_req}, {31'd0, vecs[i].e_req});
                cmp(i, "instr_valid", {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
                cmp(i, "halted", {31'd0, halted}, {31'd0, vecs[i].e_halt});
                if (vecs[i].e_req)
                    cmp(i, "imem_addr", imem_addr, vecs[i].e_addr);
                if (vecs[i].cf)
                    check_fields(i, vecs[i].e_word, vecs[i].e_pc);
            end
        end

        // Multi-cycle latency: data arrives three cycles after the 0xC0 request.
        @(negedge clk);
        imem_valid = 1'b0;  instr_ready = 1'b0;  redirect_valid = 1'b0;  redirect_pc = '0;
        @(negedge clk);
        @(negedge clk);
        imem_valid = 1'b1;  imem_rdata = 32'h2000_0000;
        @(negedge clk);
        imem_valid = 1'b0;  imem_rdata = '0;
        got = 0;  reqs = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            #1;
            if (imem_req) reqs++;
            if (instr_valid) got = 1;
            else @(negedge clk);
        end
        n_vec++;
        if (got == 0) begin
            n_err++;
            $display("FAIL slow_mem: instr_valid never rose within 10 cycles, expected 1");
        end else begin
            check_fields(100, 32'h2000_0000, 32'hC0);
        end
        n_vec++;
        cmp(101, "no_extra_req", reqs, 0);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        #1;
        n_vec++;
        cmp(102, "imem_req", {31'd0, imem_req}, 32'd1);
        cmp(102, "imem_addr", imem_addr, 32'hC4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
